dma_desc_sched: RTL and testbench

//  Parametrised descriptor scheduler for the AXI DMA: walks N CSR descriptors in ascending index order,

---
 rtl/dma_desc_sched.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_dma_desc_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_sched.sv
// -----------------------------------------------------------------------------
// dma_desc_sched
//
// Descriptor scheduler for the AXI DMA. On a rising edge of go_i it walks the
// NUM_DESC CSR descriptors in ascending index order, one per cycle. Each
// enabled descriptor with a non-zero byte count is snapshotted and issued to
// the transfer engine over a valid/ready handshake. It then waits for the
// engine's done pulse before moving on. It aggregates done/error status,
// handles abort and raises one-cycle IRQ pulses.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   go_i                       CSR go level; a run starts on its rising edge
//   abort_i                    CSR abort request (level)
//   max_burst_i                forwarded to the engine, captured at snapshot
//   desc_src_i/dst_i/byt_i     packed descriptor fields, desc i at [i*W +: W]
//   desc_en_i/wr_mode_i/rd_mode_i  per-descriptor enable and mode bits
//   eng_valid_o/eng_ready_i    request handshake to the transfer engine
//   eng_src_o/dst_o/bytes_o    snapshotted request fields
//   eng_wr_mode_o/rd_mode_o/max_burst_o  snapshotted request fields
//   eng_abort_o                abort request to the engine
//   eng_done_i/eng_error_i     engine completion pulse and its error flag
//   eng_err_addr_i             faulting address, valid with done & error
//   busy_o/done_o/error_o      status; done/error are sticky until next run
//   err_idx_o/err_addr_o       failing descriptor index and faulting address
//   irq_done_o/irq_err_o       one-cycle interrupt pulses
//
// Build option
//   DMA_DESC_LOOP_EN  when defined, a descriptor with wr_mode = rd_mode = 1
//                     is re-issued from the same snapshot until abort or error
//                     (circular mode). When undefined, the mode bits are only
//                     forwarded and each descriptor runs once.
// -----------------------------------------------------------------------------
module dma_desc_sched #(
    parameter int NUM_DESC = 4,
    parameter int ADDR_W   = 32,
    parameter int BYTES_W  = 32,
    parameter int BURST_W  = 8,
    localparam int IDX_W   = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go_i,
    input  logic                        abort_i,
    input  logic [BURST_W-1:0]          max_burst_i,
    input  logic [NUM_DESC*ADDR_W-1:0]  desc_src_i,
    input  logic [NUM_DESC*ADDR_W-1:0]  desc_dst_i,
    input  logic [NUM_DESC*BYTES_W-1:0] desc_byt_i,
    input  logic [NUM_DESC-1:0]         desc_en_i,
    input  logic [NUM_DESC-1:0]         desc_wr_mode_i,
    input  logic [NUM_DESC-1:0]         desc_rd_mode_i,
    output logic                        eng_valid_o,
    input  logic                        eng_ready_i,
    output logic [ADDR_W-1:0]           eng_src_o,
    output logic [ADDR_W-1:0]           eng_dst_o,
    output logic [BYTES_W-1:0]          eng_bytes_o,
    output logic                        eng_wr_mode_o,
    output logic                        eng_rd_mode_o,
    output logic [BURST_W-1:0]          eng_max_burst_o,
    output logic                        eng_abort_o,
    input  logic                        eng_done_i,
    input  logic                        eng_error_i,
    input  logic [ADDR_W-1:0]           eng_err_addr_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [IDX_W-1:0]            err_idx_o,
    output logic [ADDR_W-1:0]           err_addr_o,
    output logic                        irq_done_o,
    output logic                        irq_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_go_q;
    logic [IDX_W-1:0]     r_idx;
    logic [ADDR_W-1:0]    r_eng_src;
    logic [ADDR_W-1:0]    r_eng_dst;
    logic [BYTES_W-1:0]   r_eng_bytes;
    logic                 r_eng_wr_mode;
    logic                 r_eng_rd_mode;
    logic [BURST_W-1:0]   r_eng_max_burst;
    logic                 r_done;
    logic                 r_error;
    logic [IDX_W-1:0]     r_err_idx;
    logic [ADDR_W-1:0]    r_err_addr;

    logic [ADDR_W-1:0]    w_sel_src;
    logic [ADDR_W-1:0]    w_sel_dst;
    logic [BYTES_W-1:0]   w_sel_byt;
    logic                 w_sel_en;
    logic                 w_sel_wr_mode;
    logic                 w_sel_rd_mode;

    logic                 w_go_rise;
    logic                 w_last;
    logic                 w_eligible;
    logic                 w_loop_desc;
    logic                 w_start;
    logic                 w_snap;
    logic                 w_idx_inc;
    logic                 w_err_cap;
    logic                 w_enter_done;

    // Descriptor currently pointed at by r_idx. A compare-per-index mux keeps
    // the select in range for any NUM_DESC, not only powers of two.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path can leave it unassigned and infer a latch.
        w_sel_src     = '0;
        w_sel_dst     = '0;
        w_sel_byt     = '0;
        w_sel_en      = 1'b0;
        w_sel_wr_mode = 1'b0;
        w_sel_rd_mode = 1'b0;
        for (int i = 0; i < NUM_DESC; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_src     = desc_src_i[i*ADDR_W +: ADDR_W];
                w_sel_dst     = desc_dst_i[i*ADDR_W +: ADDR_W];
                w_sel_byt     = desc_byt_i[i*BYTES_W +: BYTES_W];
                w_sel_en      = desc_en_i[i];
                w_sel_wr_mode = desc_wr_mode_i[i];
                w_sel_rd_mode = desc_rd_mode_i[i];
            end
        end
    end

    assign w_go_rise  = go_i & ~r_go_q;
    assign w_last     = (r_idx == IDX_W'(NUM_DESC - 1));
    assign w_eligible = w_sel_en & (w_sel_byt != '0);

`ifdef DMA_DESC_LOOP_EN
    assign w_loop_desc = r_eng_wr_mode & r_eng_rd_mode;
`else
    assign w_loop_desc = 1'b0;
`endif

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_snap      = 1'b0;
        w_idx_inc   = 1'b0;
        w_err_cap   = 1'b0;
        eng_valid_o = 1'b0;
        eng_abort_o = 1'b0;
        busy_o      = 1'b0;
        irq_done_o  = 1'b0;
        irq_err_o   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_go_rise) begin
                    w_state_nxt = S_SCAN;
                    w_start     = 1'b1;
                end
            end
            S_SCAN: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    w_state_nxt = S_DONE;
                end else if (w_eligible) begin
                    w_state_nxt = S_ISSUE;
                    w_snap      = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            S_ISSUE: begin
                busy_o      = 1'b1;
                eng_valid_o = 1'b1;
                // A handshake completing in the same cycle as an abort has
                // already handed the request to the engine, so it must be
                // tracked to its done pulse; abort is then honoured in WAIT.
                if (eng_ready_i) begin
                    w_state_nxt = S_WAIT;
                end else if (abort_i) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                busy_o = 1'b1;
                // A done pulse takes priority over a simultaneous abort.
                if (eng_done_i) begin
                    if (eng_error_i) begin
                        w_err_cap   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_loop_desc) begin
                        w_state_nxt = abort_i ? S_DONE : S_ISSUE;
                    end else if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_inc   = 1'b1;
                        w_state_nxt = S_SCAN;
                    end
                end else if (abort_i) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                busy_o      = 1'b1;
                eng_abort_o = 1'b1;
                if (eng_done_i) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                irq_done_o  = 1'b1;
                irq_err_o   = r_error;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_go_q          <= 1'b0;
            r_idx           <= '0;
            r_eng_src       <= '0;
            r_eng_dst       <= '0;
            r_eng_bytes     <= '0;
            r_eng_wr_mode   <= 1'b0;
            r_eng_rd_mode   <= 1'b0;
            r_eng_max_burst <= '0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_err_idx       <= '0;
            r_err_addr      <= '0;
        end else begin
            r_go_q <= go_i;

            if (w_start) begin
                r_idx      <= '0;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_err_idx  <= '0;
                r_err_addr <= '0;
            end

            if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            // The snapshot isolates the engine from CSR writes made after issue.
            if (w_snap) begin
                r_eng_src       <= w_sel_src;
                r_eng_dst       <= w_sel_dst;
                r_eng_bytes     <= w_sel_byt;
                r_eng_wr_mode   <= w_sel_wr_mode;
                r_eng_rd_mode   <= w_sel_rd_mode;
                r_eng_max_burst <= max_burst_i;
            end

            if (w_err_cap) begin
                r_error    <= 1'b1;
                r_err_idx  <= r_idx;
                r_err_addr <= eng_err_addr_i;
            end

            if (w_enter_done) begin
                r_done <= 1'b1;
            end
        end
    end

    assign eng_src_o       = r_eng_src;
    assign eng_dst_o       = r_eng_dst;
    assign eng_bytes_o     = r_eng_bytes;
    assign eng_wr_mode_o   = r_eng_wr_mode;
    assign eng_rd_mode_o   = r_eng_rd_mode;
    assign eng_max_burst_o = r_eng_max_burst;
    assign done_o          = r_done;
    assign error_o         = r_error;
    assign err_idx_o       = r_err_idx;
    assign err_addr_o      = r_err_addr;

endmodule

// File: tb/tb_dma_desc_sched.sv
// -----------------------------------------------------------------------------
// tb_dma_desc_sched
//
// Self-checking bench for dma_desc_sched (NUM_DESC=4, 32-bit fields). An
// in-bench engine model answers requests with random ready stalls and done
// latencies. Each run's observed issue set and final status are compared
// against a table of hand-derived expectations and against a reference model
// that walks the descriptor list. Hand-written sequences cover start latency,
// the all-disabled run, abort in WAIT and ISSUE, stall stability and reset.
// -----------------------------------------------------------------------------
module tb_dma_desc_sched;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [7:0]    max_burst_i = '0;
    logic [ND*32-1:0] desc_src_i;
    logic [ND*32-1:0] desc_dst_i;
    logic [ND*32-1:0] desc_byt_i;
    logic [ND-1:0] desc_en_i = '0;
    logic [ND-1:0] desc_wr_mode_i = '0;
    logic [ND-1:0] desc_rd_mode_i = '0;
    logic          eng_valid_o;
    logic          eng_ready_i = 1'b0;
    logic [31:0]   eng_src_o;
    logic [31:0]   eng_dst_o;
    logic [31:0]   eng_bytes_o;
    logic          eng_wr_mode_o;
    logic          eng_rd_mode_o;
    logic [7:0]    eng_max_burst_o;
    logic          eng_abort_o;
    logic          eng_done_i = 1'b0;
    logic          eng_error_i = 1'b0;
    logic [31:0]   eng_err_addr_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [1:0]    err_idx_o;
    logic [31:0]   err_addr_o;
    logic          irq_done_o;
    logic          irq_err_o;

    logic [31:0]   d_src [ND];
    logic [31:0]   d_dst [ND];
    logic [31:0]   d_byt [ND];

    for (genvar g = 0; g < ND; g++) begin : g_pack
        assign desc_src_i[g*32 +: 32] = d_src[g];
        assign desc_dst_i[g*32 +: 32] = d_dst[g];
        assign desc_byt_i[g*32 +: 32] = d_byt[g];
    end

    dma_desc_sched #(
        .NUM_DESC(ND), .ADDR_W(32), .BYTES_W(32), .BURST_W(8)
    ) dut (
        .clk(clk), .rst(rst), .go_i(go_i), .abort_i(abort_i),
        .max_burst_i(max_burst_i),
        .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i), .desc_byt_i(desc_byt_i),
        .desc_en_i(desc_en_i), .desc_wr_mode_i(desc_wr_mode_i),
        .desc_rd_mode_i(desc_rd_mode_i),
        .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i),
        .eng_src_o(eng_src_o), .eng_dst_o(eng_dst_o), .eng_bytes_o(eng_bytes_o),
        .eng_wr_mode_o(eng_wr_mode_o), .eng_rd_mode_o(eng_rd_mode_o),
        .eng_max_burst_o(eng_max_burst_o), .eng_abort_o(eng_abort_o),
        .eng_done_i(eng_done_i), .eng_error_i(eng_error_i),
        .eng_err_addr_i(eng_err_addr_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .err_idx_o(err_idx_o), .err_addr_o(err_addr_o),
        .irq_done_o(irq_done_o), .irq_err_o(irq_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Engine error plan and captured run results.
    logic [ND-1:0] err_plan;
    logic [31:0]   plan_err_addr;
    logic [ND-1:0] r_mask;
    bit            r_order_ok;
    bit            r_timeout;
    int            r_irq_d;
    int            r_irq_e;

    typedef struct {
        logic [3:0] en;
        logic [3:0] zero;
        logic [3:0] err;
        logic [3:0] exp_mask;
        logic       exp_error;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load descriptors: zero bits force a byte count of 0.
    task automatic set_desc(input logic [3:0] en, input logic [3:0] zero, input bit rnd_bytes);
        for (int i = 0; i < ND; i++) begin
            d_src[i] = {4'(i), 28'($urandom())};
            d_dst[i] = $urandom();
            if (zero[i])        d_byt[i] = '0;
            else if (rnd_bytes) d_byt[i] = 32'($urandom_range(1, 4096));
            else                d_byt[i] = 32'd64 << i;
        end
        desc_en_i      = en;
        desc_wr_mode_i = 4'($urandom());
        desc_rd_mode_i = 4'($urandom());
        max_burst_i    = 8'($urandom());
    endtask

    // Starts a run with a go edge and plays the engine until the run's
    // irq_done pulse plus a few idle cycles; go_i stays high throughout.
    task automatic do_run(input int max_stall, input int max_lat);
        bit          seen = 0;
        bit          eng_busy = 0;
        bit          in_issue = 0;
        bit          cur_err = 0;
        int          post = 0;
        int          stall = 0;
        int          lat = 0;
        int          last_idx = -1;
        int          idx;
        logic [63:0] snap_sd;
        logic [31:0] snap_b;
        r_mask = '0; r_order_ok = 1; r_timeout = 0; r_irq_d = 0; r_irq_e = 0;
        go_i = 1'b0;
        tick();
        go_i = 1'b1;
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (irq_done_o) begin r_irq_d++; seen = 1; end
            if (irq_err_o) r_irq_e++;
            if (seen) begin
                if (post == 3) break;
                post++;
            end
            eng_ready_i = 1'b0;
            eng_done_i  = 1'b0;
            eng_error_i = 1'b0;
            if (eng_busy) begin
                if (lat == 0) begin
                    eng_done_i     = 1'b1;
                    eng_error_i    = cur_err;
                    eng_err_addr_i = cur_err ? plan_err_addr : $urandom();
                    eng_busy       = 0;
                end else begin
                    lat--;
                end
            end else if (eng_valid_o) begin
                if (!in_issue) begin
                    in_issue = 1;
                    stall    = $urandom_range(0, max_stall);
                    snap_sd  = {eng_src_o, eng_dst_o};
                    snap_b   = eng_bytes_o;
                end else begin
                    check("stall_addr", {eng_src_o, eng_dst_o}, snap_sd);
                    check("stall_bytes", eng_bytes_o, snap_b);
                end
                if (stall > 0) begin
                    stall--;
                end else begin
                    eng_ready_i = 1'b1;
                    in_issue    = 0;
                    idx         = int'(eng_src_o[31:28]);
                    if (idx >= ND) begin
                        check("issue_idx_range", 64'(idx), 64'(ND - 1));
                        idx = ND - 1;
                    end
                    if (idx <= last_idx) r_order_ok = 0;
                    last_idx  = idx;
                    r_mask[idx] = 1'b1;
                    check("issue_src", eng_src_o, d_src[idx]);
                    check("issue_dst", eng_dst_o, d_dst[idx]);
                    check("issue_bytes", eng_bytes_o, d_byt[idx]);
                    check("issue_modes", {eng_wr_mode_o, eng_rd_mode_o},
                          {desc_wr_mode_i[idx], desc_rd_mode_i[idx]});
                    check("issue_burst", eng_max_burst_o, max_burst_i);
                    eng_busy = 1;
                    lat      = $urandom_range(0, max_lat);
                    cur_err  = err_plan[idx];
                end
            end
            tick();
        end
        if (!seen) begin
            r_timeout = 1;
        end
        eng_ready_i = 1'b0;
        eng_done_i  = 1'b0;
        eng_error_i = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [3:0] exp_mask,
                             input logic exp_error, input logic [1:0] exp_idx);
        check({tag, "_timeout"}, 64'(r_timeout), 64'd0);
        check({tag, "_issued"}, r_mask, exp_mask);
        check({tag, "_order"}, 64'(r_order_ok), 64'd1);
        check({tag, "_done"}, done_o, 1'b1);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_error"}, error_o, exp_error);
        check({tag, "_err_idx"}, err_idx_o, exp_error ? exp_idx : 2'd0);
        check({tag, "_err_addr"}, err_addr_o, exp_error ? plan_err_addr : 32'd0);
        check({tag, "_irq_done_cnt"}, 64'(r_irq_d), 64'd1);
        check({tag, "_irq_err_cnt"}, 64'(r_irq_e), exp_error ? 64'd1 : 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {eng_valid_o, eng_abort_o, busy_o, done_o, error_o,
                              irq_done_o, irq_err_o, eng_wr_mode_o, eng_rd_mode_o}, '0);
        check({tag, "_eng_addr"}, {eng_src_o, eng_dst_o}, '0);
        check({tag, "_eng_bytes_burst"}, {eng_bytes_o, eng_max_burst_o}, '0);
        check({tag, "_err_fields"}, {err_addr_o, err_idx_o}, '0);
    endtask

    task automatic wait_irq(input string tag);
        for (int k = 0; k < 60 && !irq_done_o; k++) tick();
        check({tag, "_irq_done"}, irq_done_o, 1'b1);
    endtask

    initial begin
        logic [3:0] m_mask;
        logic       m_err;
        logic [1:0] m_idx;
        logic [31:0] s_src, s_dst, s_byt;
        int          cnt;

        //            en       zero     err      exp_mask exp_err idx
        vecs[0] = '{4'b0101, 4'b0000, 4'b0000, 4'b0101, 1'b0, 2'd0};
        vecs[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[2] = '{4'b1010, 4'b0010, 4'b0000, 4'b1000, 1'b0, 2'd0};
        vecs[3] = '{4'b0011, 4'b0000, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[4] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0};
        vecs[5] = '{4'b1111, 4'b0000, 4'b0100, 4'b0111, 1'b1, 2'd2};
        vecs[6] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b1, 2'd3};
        vecs[7] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0};

        set_desc(4'b0000, 4'b0000, 0);
        err_plan = '0;
        plan_err_addr = 32'h0000_1000;

        // Asynchronous reset: outputs clear without a clock edge.
        #1 rst = 1'b1;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Table-driven runs.
        for (int v = 0; v < 8; v++) begin
            set_desc(vecs[v].en, vecs[v].zero, 0);
            err_plan      = vecs[v].err;
            plan_err_addr = 32'h0000_1000;
            do_run(2, 2);
            check_run($sformatf("vec%0d", v), vecs[v].exp_mask, vecs[v].exp_error, vecs[v].exp_idx);
        end

        // Start latency: SCAN in cycle 1, request valid in cycle 2.
        set_desc(4'b0001, 4'b0000, 0);
        err_plan = '0;
        go_i = 1'b0; tick();
        go_i = 1'b1; tick();
        check("lat_c1_valid", eng_valid_o, 1'b0);
        check("lat_c1_busy", busy_o, 1'b1);
        tick();
        check("lat_c2_valid", eng_valid_o, 1'b1);
        eng_ready_i = 1'b1; tick(); eng_ready_i = 1'b0;
        eng_done_i = 1'b1; tick(); eng_done_i = 1'b0;
        wait_irq("lat");
        tick();

        // No eligible descriptor: done exactly in cycle NUM_DESC+1, no traffic,
        // and a held-high go never restarts the scheduler.
        set_desc(4'b0000, 4'b0000, 0);
        go_i = 1'b0; tick();
        go_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("none_c%0d_done", k), done_o, k == 5);
            check($sformatf("none_c%0d_valid", k), eng_valid_o, 1'b0);
        end
        check("none_irq", irq_done_o, 1'b1);
        tick();
        check("none_irq_single", irq_done_o, 1'b0);
        check("none_done_sticky", done_o, 1'b1);
        tick(); tick();
        check("none_no_restart", busy_o, 1'b0);

        // Abort while WAIT: eng_abort_o held until the engine's done.
        set_desc(4'b0011, 4'b0000, 0);
        go_i = 1'b0; tick();
        go_i = 1'b1; tick(); tick();
        eng_ready_i = 1'b1; tick(); eng_ready_i = 1'b0;
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (eng_abort_o) cnt++;
            if (k == 4) eng_done_i = 1'b1;
            tick();
            eng_done_i = 1'b0;
        end
        check("abort_wait_hold", 64'(cnt), 64'd5);
        check("abort_wait_released", eng_abort_o, 1'b0);
        check("abort_wait_done", done_o, 1'b1);
        check("abort_wait_error", error_o, 1'b0);
        check("abort_wait_irq", irq_done_o, 1'b1);
        tick(); tick();
        check("abort_wait_no_more_issue", eng_valid_o, 1'b0);

        // Abort while ISSUE stalled: valid drops, run ends, no engine traffic owed.
        go_i = 1'b0; tick();
        go_i = 1'b1; tick(); tick();
        check("abort_issue_valid", eng_valid_o, 1'b1);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        check("abort_issue_dropped", eng_valid_o, 1'b0);
        check("abort_issue_done", {done_o, error_o, irq_done_o, busy_o}, 4'b1010);
        tick();

        // Stall in ISSUE with a CSR rewrite, then reset in WAIT.
        set_desc(4'b0001, 4'b0000, 0);
        go_i = 1'b0; tick();
        go_i = 1'b1; tick(); tick();
        s_src = d_src[0]; s_dst = d_dst[0]; s_byt = d_byt[0];
        d_src[0] = ~d_src[0];
        d_byt[0] = d_byt[0] + 32'd1;
        for (int k = 0; k < 10; k++) begin
            check("stall_hold", {eng_valid_o, eng_src_o, eng_bytes_o}, {1'b1, s_src, s_byt});
            tick();
        end
        check("stall_dst", eng_dst_o, s_dst);
        eng_ready_i = 1'b1; tick(); eng_ready_i = 1'b0;
        check("wait_busy", {busy_o, eng_valid_o}, 2'b10);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        tick();
        rst = 1'b0;
        go_i = 1'b0;
        tick();
        check_all_zero("post_rst");

        // Randomised runs against the list-walking reference model.
        for (int r = 0; r < 40; r++) begin
            logic [3:0] en, zero;
            en = 4'($urandom());
            for (int i = 0; i < ND; i++) begin
                zero[i]     = ($urandom_range(0, 3) == 0);
                err_plan[i] = ($urandom_range(0, 7) == 0);
            end
            plan_err_addr = $urandom();
            set_desc(en, zero, 1);
            m_mask = '0; m_err = 0; m_idx = '0;
            for (int i = 0; i < ND; i++) begin
                if (desc_en_i[i] && d_byt[i] != 0) begin
                    m_mask[i] = 1'b1;
                    if (err_plan[i]) begin
                        m_err = 1;
                        m_idx = 2'(i);
                        break;
                    end
                end
            end
            do_run(3, 4);
            check_run($sformatf("rnd%0d", r), m_mask, m_err, m_idx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
